uart_rx_buffered: RTL and testbench

//   Receive end of our 8N1 UART link; pairs with uartTransmiter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_byte_fifo.sv | 61 ++++++
 rtl/uart_rx_buffered.sv | 123 ++++++++++++
 tb/tb_uart_rx_buffered.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame geometry and a majority-vote helper.
// Both the receiver and the transmitter import these.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StStart = START,
        StData  = DATA,
        StStop  = STOP
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO with registered overrun pulse.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module uart_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overrun_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             overrun_q;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == DepthCnt);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];
        overrun_o = overrun_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= push_i & full_o & ~do_pop;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: synchroniser, 3-sample majority voting at bit centre, framing check,
// and a byte FIFO drained over valid/ready.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serialStream,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       active
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] SampEarly = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] SampMid   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] SampLate  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] BitLast   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LastBit   = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    samp_q, samp_d;
    logic          frame_err_q, frame_err_d;
    logic          sync_rx, maj, at_mid, at_end, push, fifo_empty, fifo_full;

    always_comb begin
        sync_rx     = sync_q[1];
        maj         = majority3(samp_q[0], samp_q[1], sync_rx);
        at_mid      = (cnt_q == SampLate);
        at_end      = (cnt_q == BitLast);
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        if (cnt_q == SampEarly) samp_d[0] = sync_rx;
        if (cnt_q == SampMid)   samp_d[1] = sync_rx;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!sync_rx) state_d = StStart;
            end
            StStart: begin
                if (at_mid && maj) begin
                    state_d = StIdle;
                end else if (at_end) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (at_mid) shift_d = {maj, shift_q[7:1]};
                if (at_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == LastBit) state_d = StStop;
                    else                      bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            StStop: begin
                // Decide at the centre so the next start edge is not missed.
                if (at_mid) begin
                    state_d     = StIdle;
                    push        = maj;
                    frame_err_d = ~maj;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            samp_q      <= 2'b11;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], serialStream};
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .wdata_i   (shift_q),
        .pop_i     (rx_valid & rx_ready),
        .rdata_o   (rx_byte),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .overrun_o (overrun)
    );

    assign rx_valid  = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign active    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames, glitch rejection, framing error,
// overrun, majority-vote filtering and asynchronous reset mid-frame.
module tb_uart_rx_buffered;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serialStream;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       active;

    int checks = 0;
    int failures = 0;
    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vc0;
    logic [7:0] got [$];

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serialStream (serialStream),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .active       (active)
    );

    always #50 clk = ~clk;

    // Outputs settle after posedge; observe them on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) got.push_back(rx_byte);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        serialStream = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        serialStream = 1'b1;
    endtask

    // Same as send_frame but inverts the line for one clock at the centre of bit gbit.
    task automatic send_glitch(input logic [7:0] b, input int gbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                serialStream = b[i];
                idle(9);
                serialStream = ~b[i];
                idle(1);
                serialStream = b[i];
                idle(CPB - 10);
            end else begin
                drive_bit(b[i]);
            end
        end
        drive_bit(1'b1);
    endtask

    initial begin
        rst_n        = 1'b0;
        serialStream = 1'b1;
        rx_ready     = 1'b1;
        idle(3);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_active", active, 0);
        check("reset_rx_byte", rx_byte, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        idle(4);

        // 1: single good frame
        send_frame(8'h3F, 1'b1);
        idle(10);
        check("t1_count", got.size(), 1);
        check("t1_byte", got[0], 8'h3F);
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_frame_err", fe_cnt, 0);
        check("t1_overrun", ov_cnt, 0);

        // 2: short low glitch is rejected in START
        vc0 = valid_cycles;
        serialStream = 1'b0;
        idle(3);
        serialStream = 1'b1;
        idle(2);
        check("t2_active_start", active, 1);
        idle(20);
        check("t2_active_idle", active, 0);
        check("t2_no_valid", valid_cycles, vc0);

        // 3: framing error
        send_frame(8'hAB, 1'b0);
        idle(40);
        check("t3_frame_err_cycles", fe_cnt, 1);
        check("t3_rx_valid", rx_valid, 0);
        check("t3_count", got.size(), 1);
        check("t3_overrun", ov_cnt, 0);

        // 4: fill FIFO, fifth byte overruns
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
        idle(10);
        check("t4_rx_valid_full", rx_valid, 1);
        check("t4_head", rx_byte, 8'h01);
        check("t4_overrun_cycles", ov_cnt, 1);
        rx_ready = 1'b1;
        idle(10);
        check("t4_count", got.size(), 5);
        check("t4_pop0", got[1], 8'h01);
        check("t4_pop1", got[2], 8'h02);
        check("t4_pop2", got[3], 8'h03);
        check("t4_pop3", got[4], 8'h04);
        check("t4_drained", rx_valid, 0);

        // 5: one-clock glitch at bit 2 centre absorbed by majority vote
        send_glitch(8'hA5, 2);
        idle(10);
        check("t5_count", got.size(), 6);
        check("t5_byte", got[5], 8'hA5);

        // 6: asynchronous reset during DATA bit 4
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(5);
        check("t6_pre_valid", rx_valid, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        serialStream = 1'b1;
        idle(5);
        check("t6_pre_active", active, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_active", active, 0);
        check("t6_rst_valid", rx_valid, 0);
        idle(3);
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        idle(5);
        send_frame(8'h55, 1'b1);
        idle(10);
        check("t6_count", got.size(), 7);
        check("t6_byte", got[6], 8'h55);
        check("final_frame_err", fe_cnt, 1);
        check("final_overrun", ov_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
